// File: rtl/neopixel_pkg.sv
// neopixel_pkg: shared FSM encoding, default 12 MHz WS2812 timing and the
// byte brightness-scaling helper for the NeoPixel transmitter.
package neopixel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BIT   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // WS2812 timing at 12 MHz (83.3 ns per cycle)
  localparam int T0H_CYC_DEF  = 4;     // ~0.33 us
  localparam int T1H_CYC_DEF  = 8;     // ~0.67 us
  localparam int TBIT_CYC_DEF = 15;    // 1.25 us
  localparam int TRST_CYC_DEF = 3600;  // 300 us latch

  // (data * (level + 1)) >> 8, truncated; level 0xFF leaves data unchanged
  function automatic logic [7:0] scale_byte(input logic [7:0] data, input logic [7:0] level);
    logic [15:0] prod;
    prod = {8'd0, data} * ({8'd0, level} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/neopixel_bit_encoder.sv
// neopixel_bit_encoder: turns one data bit into a single WS2812 pulse.
// A start loads the bit and begins a TBIT_CYC-long period at phase 0; the line
// is high while phase < (bit ? T1H_CYC : T0H_CYC). done flags the final phase
// so the caller can chain the next bit with no idle cycle.
module neopixel_bit_encoder #(
  parameter int T0H_CYC  = 4,
  parameter int T1H_CYC  = 8,
  parameter int TBIT_CYC = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_bit,
  output logic o_dout,
  output logic o_done
);

  localparam int PW = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(TBIT_CYC - 1);
  localparam logic [PW-1:0] T0H_P   = PW'(T0H_CYC);
  localparam logic [PW-1:0] T1H_P   = PW'(T1H_CYC);

  logic [PW-1:0] phase_r;
  logic          active_r;
  logic          bit_r;
  logic          dout_r;
  logic [PW-1:0] phase_nxt_s;
  logic [PW-1:0] high_lim_s;

  // Next phase value and the high-time limit for the bit in flight
  always_comb begin
    phase_nxt_s = phase_r + PW'(1);
    high_lim_s  = bit_r ? T1H_P : T0H_P;
  end

  // Phase counter and registered line level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_r  <= '0;
      active_r <= 1'b0;
      bit_r    <= 1'b0;
      dout_r   <= 1'b0;
    end else if (i_start) begin
      phase_r  <= '0;
      active_r <= 1'b1;
      bit_r    <= i_bit;
      dout_r   <= 1'b1;
    end else if (active_r) begin
      if (phase_r == PH_LAST) begin
        phase_r  <= '0;
        active_r <= 1'b0;
        dout_r   <= 1'b0;
      end else begin
        phase_r <= phase_nxt_s;
        dout_r  <= (phase_nxt_s < high_lim_s);
      end
    end else begin
      dout_r <= 1'b0;
    end
  end

  assign o_dout = dout_r;
  assign o_done = active_r && (phase_r == PH_LAST);

endmodule

// File: rtl/neopixel_tx.sv
// neopixel_tx: WS2812 frame transmitter reading the frame double buffer.
// On a frame pulse it walks addresses 0..LEDS*3-1, sends each byte MSB-first
// and finishes with a TRST_CYC low latch followed by a one-cycle done pulse.
// Frame requests arriving while busy coalesce into a single pending frame.
// Optional build macro NEOPIXEL_TX_BRIGHTNESS_EN adds i_brightness, latched
// at frame start, which scales every byte as (data*(brightness+1))>>8.
module neopixel_tx
  import neopixel_pkg::*;
#(
  parameter int LEDS       = 30,
  parameter int ADDR_WIDTH = $clog2(LEDS * 3),
  parameter int T0H_CYC    = T0H_CYC_DEF,
  parameter int T1H_CYC    = T1H_CYC_DEF,
  parameter int TBIT_CYC   = TBIT_CYC_DEF,
  parameter int TRST_CYC   = TRST_CYC_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_valid,
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
  input  logic [7:0]            i_brightness,
`endif
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [7:0]            i_rd_data,
  output logic                  o_dout,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int NBYTES = LEDS * 3;
  localparam int LW     = $clog2(TRST_CYC + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NBYTES - 1);
  localparam logic [LW-1:0]         LATCH_LAST = LW'(TRST_CYC - 1);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            shift_r;
  logic [2:0]            bit_cnt_r;
  logic [LW-1:0]         latch_cnt_r;
  logic                  pending_r;
  logic                  busy_r;
  logic                  frame_done_r;

  logic [7:0]            load_byte_s;
  logic                  frame_req_s;
  logic                  latch_end_s;
  logic                  start_frame_s;
  logic                  enc_start_s;
  logic                  enc_bit_s;
  logic                  enc_done_s;

`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
  logic [7:0]            bright_r;

  // Brightness level captured at frame start, held for the whole frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bright_r <= 8'hFF;
    end else if (start_frame_s) begin
      bright_r <= i_brightness;
    end else begin
      bright_r <= bright_r;
    end
  end

  assign load_byte_s = scale_byte(i_rd_data, bright_r);
`else
  assign load_byte_s = i_rd_data;
`endif

  assign frame_req_s   = i_frame_valid | pending_r;
  assign latch_end_s   = (latch_cnt_r == LATCH_LAST);
  assign start_frame_s = ((state_r == ST_IDLE) || (state_r == ST_LATCH)) && (state_nxt_s == ST_LOAD);

  // Next-state decode and bit-encoder start control
  always_comb begin
    state_nxt_s = state_r;
    enc_start_s = 1'b0;
    enc_bit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_req_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        enc_start_s = 1'b1;
        enc_bit_s   = load_byte_s[7];
        state_nxt_s = ST_BIT;
      end
      ST_BIT: begin
        if (enc_done_s) begin
          if (bit_cnt_r != 3'd0) begin
            enc_start_s = 1'b1;
            enc_bit_s   = shift_r[6];
            state_nxt_s = ST_BIT;
          end else if (addr_r == ADDR_LAST) begin
            state_nxt_s = ST_LATCH;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_BIT;
        end
      end
      ST_LATCH: begin
        if (latch_end_s) begin
          state_nxt_s = frame_req_s ? ST_LOAD : ST_IDLE;
        end else begin
          state_nxt_s = ST_LATCH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Byte shift register, bit counter, read address and latch counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_r     <= 8'd0;
      bit_cnt_r   <= 3'd0;
      addr_r      <= '0;
      latch_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          shift_r   <= load_byte_s;
          bit_cnt_r <= 3'd7;
        end
        ST_BIT: begin
          if (enc_done_s && (bit_cnt_r != 3'd0)) begin
            shift_r   <= {shift_r[6:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - 3'd1;
          end else if (enc_done_s && (addr_r != ADDR_LAST)) begin
            addr_r <= addr_r + ADDR_WIDTH'(1);
          end else if (enc_done_s) begin
            latch_cnt_r <= '0;
          end else begin
            shift_r <= shift_r;
          end
        end
        ST_LATCH: begin
          if (latch_end_s) begin
            addr_r <= '0;
          end else begin
            latch_cnt_r <= latch_cnt_r + LW'(1);
          end
        end
        default: begin
          latch_cnt_r <= '0;
        end
      endcase
    end
  end

  // Pending request, busy flag and frame-done pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      if (start_frame_s) begin
        pending_r <= 1'b0;
      end else if (i_frame_valid && (state_r != ST_IDLE)) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      busy_r       <= (state_nxt_s != ST_IDLE);
      frame_done_r <= (state_r == ST_LATCH) && latch_end_s;
    end
  end

  neopixel_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC)
  ) u_bit_enc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(enc_start_s),
    .i_bit  (enc_bit_s),
    .o_dout (o_dout),
    .o_done (enc_done_s)
  );

  assign o_rd_addr    = addr_r;
  assign o_busy       = busy_r;
  assign o_frame_done = frame_done_r;

endmodule

// File: tb/tb_neopixel_tx.sv
// tb_neopixel_tx: directed self-checking bench for neopixel_tx with LEDS=2
// and a 50-cycle latch. The line is sampled on falling clock edges and
// decoded into per-bit high/low run lengths.
module tb_neopixel_tx;

  localparam int LEDS = 2;
  localparam int NB   = 6;
  localparam int AW   = 3;
  localparam int T0H  = 4;
  localparam int T1H  = 8;
  localparam int TBIT = 15;
  localparam int TRST = 50;
  localparam int NBITS = NB * 8;
  localparam int FRAME_BUSY = 6 * (1 + 8 * 15) + 50;  // 776

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_frame_valid = 1'b0;
  logic [AW-1:0] o_rd_addr;
  logic [7:0]    i_rd_data;
  logic          o_dout;
  logic          o_busy;
  logic          o_frame_done;
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
  logic [7:0]    i_brightness = 8'hFF;
`endif

  logic [7:0] mem       [0:NB-1];
  logic [7:0] exp_bytes [0:NB-1];

  int n_err = 0;
  int n_chk = 0;
  int hi_len [0:63];
  int lo_len [0:63];
  int addr_at[0:63];
  int nbits, busy_cycles, got_done, done_busy, first_rise;

  always #5 i_clk = ~i_clk;

  assign i_rd_data = (o_rd_addr < 3'd6) ? mem[o_rd_addr] : 8'h00;

  neopixel_tx #(
    .LEDS(LEDS), .ADDR_WIDTH(AW), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .TBIT_CYC(TBIT), .TRST_CYC(TRST)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_frame_valid(i_frame_valid),
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
    .i_brightness (i_brightness),
`endif
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_dout       (o_dout),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_valid();
    @(negedge i_clk);
    i_frame_valid = 1'b1;
    @(negedge i_clk);
    i_frame_valid = 1'b0;
  endtask

  task automatic set_mem(input logic [7:0] b0, input logic [7:0] rest);
    mem[0] = b0;
    for (int i = 1; i < NB; i++) mem[i] = rest;
    for (int i = 0; i < NB; i++) exp_bytes[i] = mem[i];
  endtask

  // Sample from the current falling edge until o_frame_done or budget
  task automatic capture(input string tag, input int budget);
    int  run;
    logic prev;
    nbits = 0; busy_cycles = 0; got_done = 0; done_busy = 0; first_rise = -1;
    run = 0; prev = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (o_busy) busy_cycles++;
      if (o_frame_done) begin
        got_done  = 1;
        done_busy = int'(o_busy);
        if (nbits > 0 && nbits <= 64) lo_len[nbits-1] = run;
        break;
      end
      if (o_dout && !prev) begin
        if (nbits > 0 && nbits <= 64) lo_len[nbits-1] = run;
        if (first_rise < 0) first_rise = c;
        if (nbits < 64) addr_at[nbits] = int'(o_rd_addr);
        run = 1;
      end else if (!o_dout && prev) begin
        if (nbits < 64) hi_len[nbits] = run;
        nbits++;
        run = 1;
      end else begin
        run++;
      end
      prev = o_dout;
      @(negedge i_clk);
    end
    chk({tag, " done_seen"}, got_done, 1);
  endtask

  // Compare decoded pulses against exp_bytes
  task automatic verify_bits(input string tag);
    int lim;
    int bitv, ehi, elo;
    chk({tag, " nbits"}, nbits, NBITS);
    lim = (nbits < NBITS) ? nbits : NBITS;
    for (int k = 0; k < lim; k++) begin
      bitv = int'(exp_bytes[k/8][7 - (k % 8)]);
      ehi  = (bitv != 0) ? T1H : T0H;
      elo  = TBIT - ehi;
      if (k == NBITS - 1) elo = elo + TRST;
      else if ((k % 8) == 7) elo = elo + 1;
      chk($sformatf("%s hi[%0d]", tag, k), hi_len[k], ehi);
      chk($sformatf("%s lo[%0d]", tag, k), lo_len[k], elo);
      chk($sformatf("%s addr[%0d]", tag, k), addr_at[k], k / 8);
    end
  endtask

  task automatic verify_frame(input string tag);
    verify_bits(tag);
    chk({tag, " busy_cycles"}, busy_cycles, FRAME_BUSY);
    chk({tag, " busy_at_done"}, done_busy, 0);
    chk({tag, " first_rise"}, first_rise, 1);
  endtask

  initial begin
    int act;
    set_mem(8'h00, 8'h00);

    // Reset for 3 cycles with random stimulus
    #1 i_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_frame_valid = 1'($urandom_range(0, 1));
      mem[0] = 8'($urandom_range(0, 255));
      #1;
      chk("rst dout", int'(o_dout), 0);
      chk("rst busy", int'(o_busy), 0);
      chk("rst done", int'(o_frame_done), 0);
      chk("rst addr", int'(o_rd_addr), 0);
    end
    @(negedge i_clk);
    i_frame_valid = 1'b0;
    i_rst = 1'b0;
    act = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_busy || o_dout || o_frame_done) act++;
    end
    chk("idle after reset", act, 0);

    // Single 1 bit followed by zeros
    set_mem(8'h80, 8'h00);
    pulse_valid();
    chk("latency busy", int'(o_busy), 1);
    chk("latency dout", int'(o_dout), 0);
    capture("f80", 2000);
    verify_frame("f80");

    // All ones
    set_mem(8'hFF, 8'hFF);
    pulse_valid();
    capture("fff", 2000);
    verify_frame("fff");

    // Two requests during a frame give exactly one follow-on frame
    set_mem(8'hA5, 8'h3C);
    pulse_valid();
    repeat (100) @(negedge i_clk);
    pulse_valid();
    repeat (100) @(negedge i_clk);
    pulse_valid();
    capture("pend1", 2000);
    chk("pend busy_at_done", done_busy, 1);
    @(negedge i_clk);
    chk("pend back2back dout", int'(o_dout), 1);
    capture("pend2", 2000);
    verify_bits("pend2");
    chk("pend2 busy_at_done", done_busy, 0);
    act = 0;
    repeat (1000) begin
      @(negedge i_clk);
      if (o_busy || o_frame_done) act++;
    end
    chk("pend no third frame", act, 0);

    // Reset while the line is high
    set_mem(8'hFF, 8'h00);
    pulse_valid();
    repeat (40) @(negedge i_clk);
    act = 0;
    while (!o_dout && act < 20) begin
      @(negedge i_clk);
      act++;
    end
    chk("midrst line high", int'(o_dout), 1);
    #2 i_rst = 1'b1;
    #1;
    chk("midrst dout async", int'(o_dout), 0);
    chk("midrst busy async", int'(o_busy), 0);
    chk("midrst addr async", int'(o_rd_addr), 0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    act = 0;
    repeat (300) begin
      @(negedge i_clk);
      if (o_busy || o_dout || o_frame_done) act++;
    end
    chk("midrst no resume", act, 0);
    set_mem(8'h5A, 8'h81);
    pulse_valid();
    chk("restart addr", int'(o_rd_addr), 0);
    capture("restart", 2000);
    verify_frame("restart");

`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
    // (0xFF * 0x80) >> 8 = 0x7F; (0xFF * 1) >> 8 = 0x00
    set_mem(8'hFF, 8'hFF);
    i_brightness = 8'h7F;
    pulse_valid();
    i_brightness = 8'h00;
    for (int i = 0; i < NB; i++) exp_bytes[i] = 8'h7F;
    capture("br7f", 2000);
    verify_bits("br7f");
    pulse_valid();
    for (int i = 0; i < NB; i++) exp_bytes[i] = 8'h00;
    capture("br00", 2000);
    verify_bits("br00");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
